// File: rtl/sm4_key_sched_if.sv
// Key-load and round-key stream signals of the SM4 key scheduler, plus a state debug tap.
// Both handshakes transfer in a cycle where valid and ready are both high; a valid payload stays put until it transfers.
interface sm4_key_sched_if;
  logic [127:0] key_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic         abort_i;
  logic [31:0]  rk_o;
  logic [4:0]   rk_idx_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         busy_o;
  logic         done_o;
  logic [4:0]   rd_idx_i;
  logic [31:0]  rd_rk_o;
  logic         keys_valid_o;
  logic [2:0]   state_o;

  modport slave (
    input  key_i, key_valid_i, abort_i, rk_ready_i, rd_idx_i,
    output key_ready_o, rk_o, rk_idx_o, rk_valid_o, busy_o, done_o,
           rd_rk_o, keys_valid_o, state_o
  );

  modport master (
    output key_i, key_valid_i, abort_i, rk_ready_i, rd_idx_i,
    input  key_ready_o, rk_o, rk_idx_o, rk_valid_o, busy_o, done_o,
           rd_rk_o, keys_valid_o, state_o
  );
endinterface

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key expansion streaming rk0..rk31 over valid/ready; PIPE=1 splits each round after the S-boxes.
// Optional round-key store enabled by the SM4_KS_STORE_EN macro.
module sm4_key_sched #(
  parameter int PIPE = 0
) (
  input logic            clk_i,
  input logic            rst_ni,
  sm4_key_sched_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    S2    = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  state_e            state_q, state_d;
  logic [3:0][31:0]  k_q, k_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       rk_q, rk_d;
  logic [4:0]        idx_q, idx_d;
  logic              rk_valid_q, rk_valid_d;
  logic              done_q, done_d;
  logic [31:0]       b_q, b_d;

  logic [31:0] ck, t, b_comb, b_use, rk_new;
  logic        accept, xfer, slot_free, fire_st, abort, fire;

  always_comb begin
    ck = '0;
    b_comb = '0;
    for (int j = 0; j < 4; j++) begin
      ck[31-8*j -: 8] = {1'b0, cnt_q, 2'(j)} * 8'd7;
    end
    t = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;
    for (int j = 0; j < 4; j++) begin
      b_comb[8*j +: 8] = sbox(t[8*j +: 8]);
    end
    b_use  = (PIPE != 0) ? b_q : b_comb;
    rk_new = k_q[0] ^ b_use ^ {b_use[18:0], b_use[31:19]} ^ {b_use[8:0], b_use[31:9]};
  end

  assign accept    = (state_q == IDLE) && bus.key_valid_i;
  assign xfer      = rk_valid_q && bus.rk_ready_i;
  assign slot_free = !rk_valid_q || bus.rk_ready_i;
  assign fire_st   = (PIPE != 0) ? (state_q == S2) : (state_q == ROUND);
  assign abort     = bus.abort_i && (state_q != IDLE);
  assign fire      = fire_st && slot_free && !abort;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    rk_d       = rk_q;
    idx_d      = idx_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    b_d        = b_q;

    if (xfer) rk_valid_d = 1'b0;

    case (state_q)
      // The key is only guaranteed during its handshake, so it is whitened at acceptance.
      IDLE: begin
        if (accept) begin
          for (int j = 0; j < 4; j++) begin
            k_d[j] = bus.key_i[127-32*j -: 32] ^ FK[127-32*j -: 32];
          end
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        if (PIPE != 0) begin
          b_d     = b_comb;
          state_d = S2;
        end
      end
      S2: ;
      DONE: begin
        if (done_q) state_d = IDLE;
        else if (xfer) done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      rk_d       = rk_new;
      idx_d      = cnt_q;
      rk_valid_d = 1'b1;
      k_d        = {rk_new, k_q[3], k_q[2], k_q[1]};
      if (cnt_q == 5'd31) begin
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q + 5'd1;
        state_d = ROUND;
      end
    end

    if (abort) begin
      state_d    = IDLE;
      rk_valid_d = 1'b0;
      cnt_d      = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      rk_q       <= '0;
      idx_q      <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      rk_q       <= rk_d;
      idx_q      <= idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      b_q        <= b_d;
    end
  end

  assign bus.key_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.rk_o        = rk_q;
  assign bus.rk_idx_o    = idx_q;
  assign bus.rk_valid_o  = rk_valid_q;
  assign bus.done_o      = done_q;
  assign bus.state_o     = state_q;

`ifdef SM4_KS_STORE_EN
  logic [31:0] store_q [32];
  logic        kv_q, kv_d;

  always_comb begin
    kv_d = kv_q;
    if (accept) kv_d = 1'b0;
    if (done_d) kv_d = 1'b1;
    if (abort)  kv_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) kv_q <= 1'b0;
    else         kv_q <= kv_d;
  end

  // Storage holds data only; validity is tracked by kv_q, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (fire) store_q[cnt_q] <= rk_new;
  end

  assign bus.rd_rk_o      = store_q[bus.rd_idx_i];
  assign bus.keys_valid_o = kv_q;
`else
  logic unused_rd_idx;
  assign unused_rd_idx    = ^bus.rd_idx_i;
  assign bus.rd_rk_o      = '0;
  assign bus.keys_valid_o = 1'b0;
`endif
endmodule

// File: doc/sm4_key_sched.md
Name: sm4_key_sched

Overview:
- Iterative SM4 key-expansion controller.
- Accepts a 128-bit master key and sequences the 32 key-expansion rounds, one per round slot, indexing the CK constant by round counter.
- Streams round keys rk0..rk31 to the cipher datapath over a valid/ready handshake.
- Sits between the key-load interface and the round-function core.

Parameters:
- PIPE, 0, 0: one round per cycle; 1: a register after the S-box layer, so each round takes 2 cycles.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- key_i  in  128  master key MK0..MK3, MK0 in [127:96]
- key_valid_i  in  1  master key valid
- key_ready_o  out  1  block idle and able to accept a key
- abort_i  in  1  synchronous abort of the expansion in progress
- rk_o  out  32  round key
- rk_idx_o  out  5  index of rk_o (0..31)
- rk_valid_o  out  1  rk_o valid
- rk_ready_i  in  1  consumer accepts rk_o
- busy_o  out  1  expansion in progress
- done_o  out  1  one-cycle pulse after rk31 is accepted
- rd_idx_i  in  5  storage read index (SM4_KS_STORE_EN only)
- rd_rk_o  out  32  stored round key (SM4_KS_STORE_EN only)
- keys_valid_o  out  1  all 32 stored keys valid (SM4_KS_STORE_EN only)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; key_ready_o=1; rk_o=0; rk_idx_o=0; rk_valid_o=0; busy_o=0; done_o=0; keys_valid_o=0; round counter=0; K0..K3=0.
- FSM states: IDLE, LOAD, ROUND, S2 (present only when PIPE=1), DONE.
- IDLE -> LOAD on key_valid_i & key_ready_o. key_ready_o=1 only in IDLE.
- LOAD (1 cycle):
  - K0..K3 <= MK ^ FK.
  - FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Counter <= 0.
  - Go to ROUND.
- ROUND, round i:
  - Compute t = K1^K2^K3^CK(i).
  - Apply 4 parallel SM4 S-boxes to get B.
  - rk = K0 ^ B ^ (B<<<13) ^ (B<<<23).
  - PIPE=0: the round fires in ROUND when output slot free, i.e. !rk_valid_o | rk_ready_i.
  - PIPE=1: ROUND registers B unconditionally and goes to S2; the L' transform and round fire happen in S2 under the same slot-free condition.
- On round fire:
  - rk_o <= rk; rk_idx_o <= i; rk_valid_o <= 1.
  - Shift K0<=K1, K1<=K2, K2<=K3, K3<=rk.
  - i <= i+1.
  - After i=31 fires, go to DONE; otherwise go to ROUND.
- Output handshake: rk_valid_o & rk_ready_i = transfer. rk_valid_o clears on transfer unless a new round fires in the same cycle. rk_o and rk_idx_o are stable while rk_valid_o & !rk_ready_i.
- DONE: waits until the rk31 transfer, then done_o=1 for one cycle and returns to IDLE.
- Latency: with a consumer always ready, rk0 is valid 2 cycles after key acceptance (PIPE=0) or 3 cycles (PIPE=1). Round keys then arrive 1 per 1+PIPE cycles. done_o comes 1 cycle after the rk31 transfer.
- busy_o = state != IDLE.
- abort_i, any non-IDLE state: next cycle state=IDLE, rk_valid_o=0, counter=0, done_o not pulsed, keys_valid_o=0. Ignored in IDLE. abort_i has priority over a simultaneous round fire.
- Counter arithmetic is 5-bit with no wrap beyond 31; the DONE transition happens instead.
- key_valid_i while busy: ignored (key_ready_o=0). A new key may be accepted in the cycle after done_o.
- Asynchronous reset mid-expansion returns all state to reset values immediately.

Optional Feature:
- Macro: SM4_KS_STORE_EN.
- Defined:
  - A 32x32 register file is written at index i on each round fire.
  - rd_rk_o = store[rd_idx_i], combinational.
  - keys_valid_o is set in the cycle done_o pulses. It clears on key acceptance, abort_i or reset.
  - Decryption reads in reverse order (31..0).
- Not defined: no storage; rd_rk_o=0 and keys_valid_o=0 constant; only the streaming interface exists.

Test Plan:
- MK=0123456789ABCDEF_FEDCBA9876543210, rk_ready_i=1, PIPE=0:
  - rk_idx 0 gives rk_o=F12186F9 two cycles after acceptance.
  - rk_idx 31 gives rk_o=9124A012.
  - 32 transfers on consecutive cycles.
  - done_o is a single pulse.
- Same MK, PIPE=1: identical keys; transfers every 2nd cycle; rk0 3 cycles after acceptance.
- rk_ready_i low for 5 cycles at rk_idx=7: rk_o and rk_idx_o hold, no round advances; sequence resumes and is unchanged.
- abort_i at rk_idx=12: next cycle IDLE, key_ready_o=1, no done_o. Reloading MK restarts from rk0=F12186F9.
- key_valid_i held high during expansion: no second load; the new key is accepted the cycle after done_o.
- SM4_KS_STORE_EN, after done_o:
  - rd_idx_i=0 gives F12186F9; rd_idx_i=31 gives 9124A012; keys_valid_o=1.
  - A new key acceptance clears keys_valid_o.
